// File: rtl/ex_muldiv_ctrl.sv
// Execute-stage sequencer for the shared iterative multiply/divide engine with HI/LO.
// Define MULDIV_EARLY_OUT_EN to let MUL finish as soon as the remaining multiplier bits are zero.
//
// state  | meaning
// IDLE   | waiting for a mul/div; MTHI/MTLO write HI/LO here
// MUL    | one shift-add iteration per cycle
// DIV    | one restoring-divide iteration per cycle
// FIX    | cnt=1: apply sign correction; cnt=0: write HI/LO and pulse o_done
module ex_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic            i_hilo_rd,
  input  logic            i_mthi,
  input  logic            i_mtlo,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_busy,
  output logic            o_stall,
  output logic            o_done,
  output logic            o_div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] opa;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   rem;
  logic              neg_lo;
  logic              neg_hi;
  logic              is_div;
  logic              div0_f;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic              done;
  logic              div0;

  logic              s1_neg;
  logic              s2_neg;
  logic [XLEN-1:0]   abs1;
  logic [XLEN-1:0]   abs2;
  logic              div_by0;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     divisor;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_next;
  logic              mul_last;
  logic              div_last;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [2*XLEN-1:0] prod_fix;

  assign s1_neg  = ~i_op[0] & i_src1[XLEN-1];
  assign s2_neg  = ~i_op[0] & i_src2[XLEN-1];
  assign abs1    = s1_neg ? -i_src1 : i_src1;
  assign abs2    = s2_neg ? -i_src2 : i_src2;
  assign div_by0 = i_op[1] & (i_src2 == '0);

  // DIV: divisor sits in opa, dividend shifts out of opb MSB while quotient bits shift in
  assign rem_sh  = {rem, opb[XLEN-1]};
  assign divisor = {1'b0, opa[XLEN-1:0]};
  assign rem_ge  = (rem_sh >= divisor);

  always_comb begin
    rem_next = rem_sh[XLEN-1:0];
    if (rem_ge) rem_next = XLEN'(rem_sh - divisor);
  end

`ifdef MULDIV_EARLY_OUT_EN
  // multiplicand is pre-shifted each step, so stopping early leaves acc already aligned
  assign mul_last = (opb[XLEN-1:1] == '0);
`else
  assign mul_last = (cnt == CNT_W'(1));
`endif
  assign div_last = (cnt == CNT_W'(1));

  assign quo_fix  = neg_lo ? -opb : opb;
  assign rem_fix  = neg_hi ? -rem : rem;
  assign prod_fix = neg_lo ? -acc : acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      rem    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
      div0_f <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      if (i_flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_mthi) hi <= i_src1;
            if (i_mtlo) lo <= i_src1;
            if (i_start) begin
              opa    <= {{XLEN{1'b0}}, (i_op[1] ? abs2 : abs1)};
              opb    <= i_op[1] ? abs1 : abs2;
              acc    <= '0;
              rem    <= '0;
              is_div <= i_op[1];
              cnt    <= CNT_W'(XLEN);
              if (div_by0) begin
                acc    <= {i_src1, {XLEN{1'b1}}};
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                div0_f <= 1'b1;
                cnt    <= CNT_W'(1);
                state  <= S_FIX;
              end else begin
                neg_lo <= s1_neg ^ s2_neg;
                neg_hi <= s1_neg;
                div0_f <= 1'b0;
                state  <= i_op[1] ? S_DIV : S_MUL;
              end
            end
          end
          S_MUL: begin
            if (opb[0]) acc <= acc + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
            cnt <= cnt - CNT_W'(1);
            if (mul_last) begin
              cnt   <= CNT_W'(1);
              state <= S_FIX;
            end
          end
          S_DIV: begin
            rem <= rem_next;
            opb <= {opb[XLEN-2:0], rem_ge};
            cnt <= cnt - CNT_W'(1);
            if (div_last) begin
              cnt   <= CNT_W'(1);
              state <= S_FIX;
            end
          end
          default: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
              if (!div0_f) acc <= is_div ? {rem_fix, quo_fix} : prod_fix;
            end else begin
              hi    <= acc[2*XLEN-1:XLEN];
              lo    <= acc[XLEN-1:0];
              done  <= 1'b1;
              div0  <= div0_f;
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign o_hi    = hi;
  assign o_lo    = lo;
  assign o_busy  = (state != S_IDLE);
  assign o_stall = o_busy & (i_start | i_hilo_rd | i_mthi | i_mtlo);
  assign o_done  = done;
  assign o_div0  = div0;

endmodule
